// File: rtl/m_serial_add_ctrl_pkg.sv
// Shared CPU-wide constants and the serial adder sequencer state encoding.
`timescale 1ns/1ps
package m_serial_add_ctrl_pkg;

   localparam int CPU_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/m_FullAdder.sv
// One-bit full-adder cell, the single arithmetic slice reused by the serial sequencer.
`timescale 1ns/1ps
module m_FullAdder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/m_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell walks the operands LSB-first
// over WIDTH cycles, then holds sum/carry/overflow/zero until the consumer takes them.
`timescale 1ns/1ps
module m_serial_add_ctrl
   import m_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_overflow,
   output logic             o_zero
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q;
   logic             ready_q;
   logic             valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-2:0] sh_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] sum_d;
   logic             last_bit;

   m_FullAdder u_fa (
      .i_a    (a_q[0]),
      .i_b    (b_q[0]),
      .i_cin  (carry_q),
      .o_sum  (fa_sum),
      .o_cout (fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
   assign sum_d    = {fa_sum, sh_q};
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else if (i_flush) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  a_q     <= i_a;
                  b_q     <= i_b ^ {WIDTH{i_sub}};
                  carry_q <= i_sub | i_cin;
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
                  ready_q <= 1'b0;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               sh_q    <= sum_d[WIDTH-1:1];
               carry_q <= fa_cout;
               cnt_q   <= cnt_q + CW'(1);
               if (last_bit) begin
                  // carry_q here is the carry into the MSB slice.
                  sum_q   <= sum_d;
                  cout_q  <= fa_cout;
                  ovf_q   <= carry_q ^ fa_cout;
                  zero_q  <= (sum_d == '0);
                  state_q <= ST_DONE;
                  valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready    = ready_q;
   assign o_valid    = valid_q;
   assign o_sum      = sum_q;
   assign o_cout     = cout_q;
   assign o_overflow = ovf_q;
   assign o_zero     = zero_q;

endmodule

// File: tb/tb_m_serial_add_ctrl.sv
// Scoreboard bench for the serial add/subtract sequencer using hand-computed vectors.
`timescale 1ns/1ps
module tb_m_serial_add_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vld = 1'b0;
   logic          rdy_o;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          flush = 1'b0;
   logic          ovalid;
   logic          cons_rdy = 1'b1;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          zero;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int first_cyc = -1;

   m_serial_add_ctrl #(.WIDTH(W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (vld),
      .o_ready    (rdy_o),
      .i_a        (a),
      .i_b        (b),
      .i_cin      (cin),
      .i_sub      (sub),
      .i_flush    (flush),
      .o_valid    (ovalid),
      .i_ready    (cons_rdy),
      .o_sum      (sum),
      .o_cout     (cout),
      .o_overflow (ovf),
      .o_zero     (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
   endtask

   // Monitor: compares against the scoreboard on every result handshake.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         first_cyc = -1;
      end else if (ovalid) begin
         if (first_cyc < 0) first_cyc = cyc;
         if (cons_rdy) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", {31'd0, ovalid}, 32'd0);
            end else begin
               e = sb.pop_front();
               $display("txn %s: sum=%h cout=%b ovf=%b zero=%b latency=%0d",
                        e.name, sum, cout, ovf, zero, first_cyc - e.acc);
               chk({e.name, "_sum"},  {16'd0, sum},  {16'd0, e.sum});
               chk({e.name, "_cout"}, {31'd0, cout}, {31'd0, e.cout});
               chk({e.name, "_ovf"},  {31'd0, ovf},  {31'd0, e.ovf});
               chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
               chk({e.name, "_latency"}, first_cyc - e.acc, W);
            end
            first_cyc = -1;
         end
      end
   end

   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic isub, input bit push, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez, input string nm);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!rdy_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_o) chk({nm, "_ready_timeout"}, {31'd0, rdy_o}, 32'd1);
      a = ia; b = ib; cin = icin; sub = isub; vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld = 1'b0;
      if (push) begin
         e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.acc = cyc; e.name = nm;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !rdy_o) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic seen;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, ovalid}, 32'd0);
      chk("rst_sum",   {16'd0, sum},    32'd0);
      chk("rst_cout",  {31'd0, cout},   32'd0);
      chk("rst_ovf",   {31'd0, ovf},    32'd0);
      chk("rst_zero",  {31'd0, zero},   32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, rdy_o}, 32'd1);

      issue(16'h0001, 16'hFFFF, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1, "add_wrap");
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
      issue(16'h1234, 16'h0001, 1'b1, 1'b0, 1, 16'h1236, 1'b0, 1'b0, 1'b0, "add_cin");
      issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
      issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
      issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 1'b1, "add_negovf");
      drain();

      // Backpressure: result held for 10 cycles while new operands are offered.
      cons_rdy = 1'b0;
      issue(16'h1234, 16'h1234, 1'b0, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 1'b1, "sub_equal_bp");
      for (int n = 0; n < 100 && !ovalid; n++) @(negedge clk);
      chk("bp_valid_seen", {31'd0, ovalid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = 16'hFFFF; b = 16'h0001; sub = 1'b0; vld = 1'b1;
         chk("bp_sum_stable", {16'd0, sum}, 32'd0);
         chk("bp_valid_held", {31'd0, ovalid}, 32'd1);
         chk("bp_not_ready",  {31'd0, rdy_o},  32'd0);
      end
      vld = 1'b0;
      cons_rdy = 1'b1;
      drain();
      repeat (20) @(negedge clk);
      chk("bp_no_spurious", sb.size() + {31'd0, ~rdy_o}, 0);

      // Flush at RUN bit 7.
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, "flushed");
      repeat (7) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", {31'd0, rdy_o},  32'd1);
      chk("flush_valid", {31'd0, ovalid}, 32'd0);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         seen = seen | ovalid;
      end
      chk("flush_no_valid", {31'd0, seen}, 32'd0);
      issue(16'h0002, 16'h0003, 1'b0, 1'b0, 1, 16'h0005, 1'b0, 1'b0, 1'b0, "after_flush");
      drain();

      // Asynchronous reset at RUN bit 9.
      issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, "reset_abort");
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, ovalid}, 32'd0);
      chk("midrst_sum",   {16'd0, sum},    32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", {31'd0, rdy_o},  32'd1);
      chk("midrst_zero",  {31'd0, zero},   32'd1);
      chk("midrst_idle_valid", {31'd0, ovalid}, 32'd0);
      issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1, 16'hFFFF, 1'b1, 1'b0, 1'b0, "after_reset");
      drain();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
